// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 second-shuffle (PRGA) decrypt stage.
package rc4_pkg;

  localparam int MSG_LEN_DEF = 32;
  localparam int MSG_AW_DEF  = 5;

  localparam logic [7:0] ASCII_LO    = 8'h61;
  localparam logic [7:0] ASCII_HI    = 8'h7A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD_SI,
    ST_WAIT_SI,
    ST_LATCH_SI,
    ST_RD_SJ,
    ST_WAIT_SJ,
    ST_LATCH_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_WR_DEC,
    ST_NEXT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Sequencer handshake plus S RAM / encrypted ROM / decrypted RAM ports of the PRGA stage.
interface rc4_prga_decrypt_if
  import rc4_pkg::*;
#(parameter int MSG_AW = MSG_AW_DEF);

  logic              start;
  logic              done;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] enc_addr;
  logic [7:0]        enc_rdata;
  logic [MSG_AW-1:0] dec_addr;
  logic [7:0]        dec_wdata;
  logic              dec_wren;
  logic              key_invalid;

  modport master (
    input  start, s_rdata, enc_rdata,
    output done, s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren, key_invalid
  );

  modport slave (
    output start, s_rdata, enc_rdata,
    input  done, s_addr, s_wdata, s_wren, enc_addr, dec_addr, dec_wdata, dec_wren, key_invalid
  );

endinterface

// File: rtl/rc4_ascii_check.sv
// Plaintext byte filter: accepts lowercase 'a'..'z' and space only.
module rc4_ascii_check
  import rc4_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       valid
);

  assign valid = ((byte_in >= ASCII_LO) && (byte_in <= ASCII_HI)) || (byte_in == ASCII_SPACE);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA stage: generates keystream from S RAM, XORs with the encrypted ROM, writes plaintext.
// Optional early abort on non-text plaintext when RC4_PLAINTEXT_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | wait for start
// INIT     | i=1, j=0, k=0
// *_SI     | read S[i] (RD, WAIT, LATCH), j += S[i]
// *_SJ     | read S[j] (RD, WAIT, LATCH)
// WR_SI/SJ | swap: S[i]=sj, then S[j]=si
// RD_F     | read S[si+sj] and enc[k]
// WAIT_F   | memory latency
// WR_DEC   | dec[k] = S[f] ^ enc[k]
// NEXT     | advance or finish
// DONE     | done high until start drops
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEF,
  parameter int MSG_AW  = MSG_AW_DEF
)
(
  input  logic                CLOCK_50,
  input  logic                reset,
  rc4_prga_decrypt_if.master  bus
);

  state_t            state;
  logic [7:0]        i, j, k, si, sj;
  logic [7:0]        s_addr_q, s_wdata_q;
  logic              s_wren_q, dec_wren_q, done_q;
  logic [MSG_AW-1:0] enc_addr_q, dec_addr_q;
  logic [7:0]        dec_byte;
  logic              last_byte, stop_early;

  assign dec_byte  = bus.s_rdata ^ bus.enc_rdata;
  assign last_byte = (k == 8'(MSG_LEN - 1));

`ifdef RC4_PLAINTEXT_CHECK_EN
  logic byte_ok, key_inv_q;
  rc4_ascii_check u_ascii_check (.byte_in(dec_byte), .valid(byte_ok));
  assign stop_early      = key_inv_q;
  assign bus.key_invalid = key_inv_q;
`else
  assign stop_early      = 1'b0;
  assign bus.key_invalid = 1'b0;
`endif

  assign bus.s_addr    = s_addr_q;
  assign bus.s_wdata   = s_wdata_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.enc_addr  = enc_addr_q;
  assign bus.dec_addr  = dec_addr_q;
  assign bus.dec_wren  = dec_wren_q;
  // Memory addresses stay put through WR_DEC, so the XOR can be taken straight off the read data.
  assign bus.dec_wdata = dec_wren_q ? dec_byte : 8'h00;
  assign bus.done      = done_q;

  // Outputs are registered one state ahead so each holds its value for the whole target state.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      i          <= 8'h00;
      j          <= 8'h00;
      k          <= 8'h00;
      si         <= 8'h00;
      sj         <= 8'h00;
      s_addr_q   <= 8'h00;
      s_wdata_q  <= 8'h00;
      s_wren_q   <= 1'b0;
      enc_addr_q <= '0;
      dec_addr_q <= '0;
      dec_wren_q <= 1'b0;
      done_q     <= 1'b0;
`ifdef RC4_PLAINTEXT_CHECK_EN
      key_inv_q  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE:     if (bus.start) state <= ST_INIT;
        ST_INIT: begin
          i        <= 8'h01;
          j        <= 8'h00;
          k        <= 8'h00;
          s_addr_q <= 8'h01;
`ifdef RC4_PLAINTEXT_CHECK_EN
          key_inv_q <= 1'b0;
`endif
          state    <= ST_RD_SI;
        end
        ST_RD_SI:    state <= ST_WAIT_SI;
        ST_WAIT_SI:  state <= ST_LATCH_SI;
        ST_LATCH_SI: begin
          si       <= bus.s_rdata;
          j        <= j + bus.s_rdata;
          s_addr_q <= j + bus.s_rdata;
          state    <= ST_RD_SJ;
        end
        ST_RD_SJ:    state <= ST_WAIT_SJ;
        ST_WAIT_SJ:  state <= ST_LATCH_SJ;
        ST_LATCH_SJ: begin
          sj        <= bus.s_rdata;
          s_addr_q  <= i;
          s_wdata_q <= bus.s_rdata;
          s_wren_q  <= 1'b1;
          state     <= ST_WR_SI;
        end
        ST_WR_SI: begin
          s_addr_q  <= j;
          s_wdata_q <= si;
          state     <= ST_WR_SJ;
        end
        ST_WR_SJ: begin
          s_addr_q   <= si + sj;
          s_wdata_q  <= 8'h00;
          s_wren_q   <= 1'b0;
          enc_addr_q <= k[MSG_AW-1:0];
          state      <= ST_RD_F;
        end
        ST_RD_F:     state <= ST_WAIT_F;
        ST_WAIT_F: begin
          dec_addr_q <= k[MSG_AW-1:0];
          dec_wren_q <= 1'b1;
          state      <= ST_WR_DEC;
        end
        ST_WR_DEC: begin
          dec_wren_q <= 1'b0;
`ifdef RC4_PLAINTEXT_CHECK_EN
          if (!byte_ok) key_inv_q <= 1'b1;
`endif
          state      <= ST_NEXT;
        end
        ST_NEXT: begin
          if (last_byte || stop_early) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end else begin
            k        <= k + 8'd1;
            i        <= i + 8'd1;
            s_addr_q <= i + 8'd1;
            state    <= ST_RD_SI;
          end
        end
        ST_DONE: begin
          if (!bus.start) begin
            done_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: two instances (MSG_LEN=4 and MSG_LEN=1) with behavioural memories.
module tb_rc4_prga_decrypt;

  logic CLOCK_50;
  logic reset;
  int   n_tests;
  int   n_fail;

  rc4_prga_decrypt_if #(.MSG_AW(5)) bus_a ();
  rc4_prga_decrypt_if #(.MSG_AW(5)) bus_b ();

  rc4_prga_decrypt #(.MSG_LEN(4), .MSG_AW(5)) u_dut_a (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_a));
  rc4_prga_decrypt #(.MSG_LEN(1), .MSG_AW(5)) u_dut_b (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus_b));

  logic [7:0] s_mem_a [256];
  logic [7:0] enc_mem_a [32];
  logic [7:0] dec_mem_a [32];
  logic [7:0] s_mem_b [256];
  logic [7:0] enc_mem_b [32];
  logic [7:0] dec_mem_b [32];

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    if (bus_a.s_wren) s_mem_a[bus_a.s_addr] <= bus_a.s_wdata;
    if (bus_a.dec_wren) dec_mem_a[bus_a.dec_addr] <= bus_a.dec_wdata;
    bus_a.s_rdata   <= s_mem_a[bus_a.s_addr];
    bus_a.enc_rdata <= enc_mem_a[bus_a.enc_addr];
    if (bus_b.s_wren) s_mem_b[bus_b.s_addr] <= bus_b.s_wdata;
    if (bus_b.dec_wren) dec_mem_b[bus_b.dec_addr] <= bus_b.dec_wdata;
    bus_b.s_rdata   <= s_mem_b[bus_b.s_addr];
    bus_b.enc_rdata <= enc_mem_b[bus_b.enc_addr];
  end

  task automatic load_a(input logic [7:0] enc0);
    @(negedge CLOCK_50);
    for (int a = 0; a < 256; a++) s_mem_a[a] <= 8'(a);
    for (int a = 0; a < 32; a++) begin
      enc_mem_a[a] <= (a == 0) ? enc0 : 8'h00;
      dec_mem_a[a] <= 8'hEE;
    end
    @(negedge CLOCK_50);
  endtask

  // Starts instance A, counts edges after the one sampling start, tallies writes outside their slots.
  task automatic run_a(input int nexp, input int drop_at, output int cnt, output int wr_err);
    logic exp_s, exp_d;
    int   ph;
    cnt = 0;
    wr_err = 0;
    @(negedge CLOCK_50);
    bus_a.start = 1'b1;
    @(posedge CLOCK_50);
    for (int e = 1; e <= 600; e++) begin
      @(posedge CLOCK_50);
      #1;
      cnt = e;
      if (e == drop_at) bus_a.start = 1'b0;
      ph = (e - 1) % 12;
      exp_s = (e <= 12 * nexp) && (ph == 6 || ph == 7);
      exp_d = (e <= 12 * nexp) && (ph == 10);
      if (bus_a.s_wren !== exp_s || bus_a.dec_wren !== exp_d) wr_err++;
      if (bus_a.done === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    logic [37:0] outs;
    reset = 1'b1;
    #12;
    outs = {bus_a.s_addr, bus_a.s_wdata, bus_a.s_wren, bus_a.enc_addr, bus_a.dec_addr,
            bus_a.dec_wdata, bus_a.dec_wren, bus_a.done, bus_a.key_invalid};
    n_tests++;
    if (outs !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    n_tests++;
    if (bus_a.done !== 1'b0 || bus_a.s_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_quiet: done=%b s_wren=%b expected 0,0", bus_a.done, bus_a.s_wren);
    end
  endtask

  task automatic check_dec_a(input string tag);
    logic [7:0] exp_dec [4];
    exp_dec = '{8'h02, 8'h05, 8'h07, 8'h0D};
    for (int n = 0; n < 4; n++) begin
      n_tests++;
      if (dec_mem_a[n] !== exp_dec[n]) begin
        n_fail++;
        $display("FAIL %s dec[%0d]: got %h expected %h", tag, n, dec_mem_a[n], exp_dec[n]);
      end
    end
  endtask

  task automatic test_identity;
    int cnt, err;
    logic [7:0] exp_s [5];
    load_a(8'h00);
    run_a(4, -1, cnt, err);
    n_tests++;
    if (cnt !== 49) begin n_fail++; $display("FAIL ident_done_edge: got %0d expected 49", cnt); end
    n_tests++;
    if (err !== 0) begin n_fail++; $display("FAIL ident_write_slots: got %0d stray expected 0", err); end
    check_dec_a("ident");
    exp_s = '{8'h01, 8'h03, 8'h05, 8'h09, 8'h02};
    for (int n = 0; n < 5; n++) begin
      n_tests++;
      if (s_mem_a[n + 1] !== exp_s[n]) begin
        n_fail++;
        $display("FAIL ident_S[%0d]: got %h expected %h", n + 1, s_mem_a[n + 1], exp_s[n]);
      end
    end
    n_tests++;
    if (s_mem_a[9] !== 8'h04) begin n_fail++; $display("FAIL ident_S[9]: got %h expected 04", s_mem_a[9]); end
    n_tests++;
    if (dec_mem_a[4] !== 8'hEE) begin n_fail++; $display("FAIL ident_dec4_untouched: got %h expected ee", dec_mem_a[4]); end
    n_tests++;
    if (bus_a.key_invalid !== 1'b0) begin n_fail++; $display("FAIL ident_key_invalid: got %b expected 0", bus_a.key_invalid); end
    repeat (3) @(negedge CLOCK_50);
    n_tests++;
    if (bus_a.done !== 1'b1 || bus_a.s_wren !== 1'b0 || bus_a.dec_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL done_hold: done=%b s_wren=%b dec_wren=%b expected 1,0,0", bus_a.done, bus_a.s_wren, bus_a.dec_wren);
    end
    bus_a.start = 1'b0;
    @(posedge CLOCK_50);
    #1;
    n_tests++;
    if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL done_release: got %b expected 0", bus_a.done); end
  endtask

  task automatic test_wrap;
    int cnt;
    @(negedge CLOCK_50);
    for (int a = 0; a < 256; a++) s_mem_b[a] <= 8'(a);
    s_mem_b[1]   <= 8'hFF;
    s_mem_b[255] <= 8'h10;
    for (int a = 0; a < 32; a++) begin
      enc_mem_b[a] <= (a == 0) ? 8'hA5 : 8'h00;
      dec_mem_b[a] <= 8'hEE;
    end
    @(negedge CLOCK_50);
    bus_b.start = 1'b1;
    @(posedge CLOCK_50);
    cnt = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge CLOCK_50);
      #1;
      if (bus_b.done === 1'b1) begin cnt = e; break; end
    end
    bus_b.start = 1'b0;
    n_tests++;
    if (cnt !== 13) begin n_fail++; $display("FAIL wrap_done_edge: got %0d expected 13", cnt); end
    n_tests++;
    if (dec_mem_b[0] !== 8'hAA) begin n_fail++; $display("FAIL wrap_dec0: got %h expected aa", dec_mem_b[0]); end
    n_tests++;
    if (s_mem_b[1] !== 8'h10 || s_mem_b[255] !== 8'hFF) begin
      n_fail++;
      $display("FAIL wrap_swap: S1=%h S255=%h expected 10,ff", s_mem_b[1], s_mem_b[255]);
    end
    n_tests++;
    if (dec_mem_b[1] !== 8'hEE) begin n_fail++; $display("FAIL wrap_dec1_untouched: got %h expected ee", dec_mem_b[1]); end
  endtask

  task automatic test_start_drop;
    int cnt, err;
    load_a(8'h00);
    run_a(4, 29, cnt, err);
    n_tests++;
    if (cnt !== 49) begin n_fail++; $display("FAIL drop_done_edge: got %0d expected 49", cnt); end
    n_tests++;
    if (err !== 0) begin n_fail++; $display("FAIL drop_write_slots: got %0d stray expected 0", err); end
    check_dec_a("drop");
    @(posedge CLOCK_50);
    #1;
    n_tests++;
    if (bus_a.done !== 1'b0) begin n_fail++; $display("FAIL drop_done_pulse: got %b expected 0", bus_a.done); end
    repeat (3) @(posedge CLOCK_50);
    #1;
    n_tests++;
    if (bus_a.s_wren !== 1'b0 || bus_a.dec_wren !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_writes: s_wren=%b dec_wren=%b expected 0,0", bus_a.s_wren, bus_a.dec_wren);
    end
  endtask

  task automatic test_reset_mid;
    int cnt, err;
    logic [37:0] outs;
    load_a(8'h00);
    bus_a.start = 1'b1;
    @(posedge CLOCK_50);
    for (int e = 1; e <= 8; e++) begin
      @(posedge CLOCK_50);
      #1;
    end
    n_tests++;
    if (bus_a.s_wren !== 1'b1 || bus_a.s_addr !== 8'h01) begin
      n_fail++;
      $display("FAIL midrun_wr_sj: s_wren=%b s_addr=%h expected 1,01", bus_a.s_wren, bus_a.s_addr);
    end
    reset = 1'b1;
    #1;
    outs = {bus_a.s_addr, bus_a.s_wdata, bus_a.s_wren, bus_a.enc_addr, bus_a.dec_addr,
            bus_a.dec_wdata, bus_a.dec_wren, bus_a.done, bus_a.key_invalid};
    n_tests++;
    if (outs !== 38'h0) begin n_fail++; $display("FAIL midrun_reset_outputs: got %h expected 0", outs); end
    bus_a.start = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    load_a(8'h00);
    run_a(4, -1, cnt, err);
    n_tests++;
    if (cnt !== 49 || err !== 0) begin
      n_fail++;
      $display("FAIL restart_run: edge=%0d stray=%0d expected 49,0", cnt, err);
    end
    check_dec_a("restart");
    bus_a.start = 1'b0;
    repeat (2) @(negedge CLOCK_50);
  endtask

`ifdef RC4_PLAINTEXT_CHECK_EN
  task automatic test_plaintext_check;
    int cnt, err;
    load_a(8'h63);
    run_a(2, -1, cnt, err);
    n_tests++;
    if (cnt !== 25) begin n_fail++; $display("FAIL pt_done_edge: got %0d expected 25", cnt); end
    n_tests++;
    if (err !== 0) begin n_fail++; $display("FAIL pt_write_slots: got %0d stray expected 0", err); end
    n_tests++;
    if (bus_a.key_invalid !== 1'b1) begin n_fail++; $display("FAIL pt_key_invalid: got %b expected 1", bus_a.key_invalid); end
    n_tests++;
    if (dec_mem_a[0] !== 8'h61 || dec_mem_a[1] !== 8'h05) begin
      n_fail++;
      $display("FAIL pt_dec01: got %h %h expected 61 05", dec_mem_a[0], dec_mem_a[1]);
    end
    n_tests++;
    if (dec_mem_a[2] !== 8'hEE || dec_mem_a[3] !== 8'hEE) begin
      n_fail++;
      $display("FAIL pt_dec_untouched: got %h %h expected ee ee", dec_mem_a[2], dec_mem_a[3]);
    end
    bus_a.start = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    n_tests++;
    if (bus_a.key_invalid !== 1'b1) begin n_fail++; $display("FAIL pt_key_hold: got %b expected 1", bus_a.key_invalid); end
    bus_a.start = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;
    n_tests++;
    if (bus_a.key_invalid !== 1'b0) begin n_fail++; $display("FAIL pt_init_clear: got %b expected 0", bus_a.key_invalid); end
    bus_a.start = 1'b0;
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask
`endif

  initial begin
    CLOCK_50    = 1'b0;
    reset       = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    n_tests     = 0;
    n_fail      = 0;
    test_reset;
    test_wrap;
`ifdef RC4_PLAINTEXT_CHECK_EN
    test_plaintext_check;
`else
    test_identity;
    test_start_drop;
    test_reset_mid;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
